// File: rtl/rf_param.sv
// Parameterised register file with forwarding, per-register pending bits and a sweep-clear FSM.
// Define RF_TRACE_EN to print the array, FSM state and pend vector on every rising clk edge.
module rf_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] WD,
  input  logic              RFWr,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   idx, idx_nxt;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]    pend;

  logic wr_ok, rsv_ok, sweep_start, sweep_last;

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    clr_busy    = 1'b0;
    sweep_start = 1'b0;
    sweep_last  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          idx_nxt     = ADDR_W'(1);
          sweep_start = 1'b1;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        // Index saturates at the top entry; the sweep ends on that write.
        if (idx == {ADDR_W{1'b1}}) begin
          state_nxt  = IDLE;
          sweep_last = 1'b1;
        end else begin
          idx_nxt = idx + ADDR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_ok  = RFWr && (rd != '0) && !clr_busy;
  assign rsv_ok = rsv_en && (rsv_addr != '0) && !clr_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clr_busy) begin
      regs[idx] <= '0;
    end else if (wr_ok) begin
      regs[rd] <= WD;
    end
  end

  // Reserve is applied after the write-clear so it wins on the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (sweep_start) begin
      pend <= '0;
    end else begin
      if (wr_ok)  pend[rd]       <= 1'b0;
      if (rsv_ok) pend[rsv_addr] <= 1'b1;
    end
  end

  logic byp1, byp2;
  assign byp1 = BYPASS && wr_ok && !rst && (rd == rs);
  assign byp2 = BYPASS && wr_ok && !rst && (rd == rt);

  always_comb begin
    RD1 = regs[rs];
    RD2 = regs[rt];
    if (rs == '0)  RD1 = '0;
    else if (byp1) RD1 = WD;
    if (rt == '0)  RD2 = '0;
    else if (byp2) RD2 = WD;
  end

  assign rs_busy = pend[rs];
  assign rt_busy = pend[rt];

  logic unused_last;
  assign unused_last = sweep_last;

`ifdef RF_TRACE_EN
  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      $write("%8X ", regs[i]);
      if (i % 8 == 7) $write("\n");
    end
    $display("state=%s pend=%b", state.name(), pend);
  end
`else
`endif

endmodule

// File: tb/tb_rf_param.sv
// Directed bench: BYPASS=1 and BYPASS=0 instances share all inputs.
module tb_rf_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, rd, rsv_addr;
  logic [31:0] WD;
  logic        RFWr, rsv_en, clr_req;

  logic [31:0] RD1_a, RD2_a, RD1_b, RD2_b;
  logic        rs_busy_a, rt_busy_a, clr_busy_a;
  logic        rs_busy_b, rt_busy_b, clr_busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  always #5 clk = ~clk;

  rf_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .WD(WD), .RFWr(RFWr),
    .RD1(RD1_a), .RD2(RD2_a), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rs_busy(rs_busy_a), .rt_busy(rt_busy_a), .clr_req(clr_req), .clr_busy(clr_busy_a)
  );

  rf_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .WD(WD), .RFWr(RFWr),
    .RD1(RD1_b), .RD2(RD2_b), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rs_busy(rs_busy_b), .rt_busy(rt_busy_b), .clr_req(clr_req), .clr_busy(clr_busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rs = 5'd3; rt = 5'd3; rd = 5'd3; WD = 32'hCAFEF00D;
    RFWr = 1'b1; rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
    #3;
    chk("rst_rd1_byp", RD1_a, 32'h0);
    chk("rst_rd2_byp", RD2_a, 32'h0);
    chk("rst_busy", {29'd0, rs_busy_a, rt_busy_a, clr_busy_a}, 32'h0);
    tick; tick;
    chk("rst_hold_rd1", RD1_b, 32'h0);
    rst = 1'b0; RFWr = 1'b0;
    tick;

    // Same-cycle forwarding vs. next-cycle visibility
    rd = 5'd5; rs = 5'd5; WD = 32'hDEADBEEF; RFWr = 1'b1;
    #1;
    chk("byp_same_cycle", RD1_a, 32'hDEADBEEF);
    chk("nobyp_old_val", RD1_b, 32'h0);
    tick;
    RFWr = 1'b0; rt = 5'd5;
    #1;
    chk("nobyp_next_cycle", RD1_b, 32'hDEADBEEF);
    chk("byp_stored", RD1_a, 32'hDEADBEEF);
    chk("rd2_port", RD2_b, 32'hDEADBEEF);

    // Register 0 is hardwired
    rd = 5'd0; rs = 5'd0; WD = 32'h12345678; RFWr = 1'b1;
    #1;
    chk("r0_no_bypass", RD1_a, 32'h0);
    tick;
    RFWr = 1'b0;
    #1;
    chk("r0_after_write", RD1_b, 32'h0);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    tick;
    rsv_en = 1'b0;
    #1;
    chk("r0_never_busy", {31'd0, rs_busy_a}, 32'h0);

    // Reserve then write clears pending
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick;
    rsv_en = 1'b0; rs = 5'd7; rt = 5'd7;
    #1;
    chk("r7_reserved", {31'd0, rs_busy_a}, 32'h1);
    chk("r7_rt_busy", {31'd0, rt_busy_b}, 32'h1);
    rd = 5'd7; WD = 32'h1; RFWr = 1'b1;
    #1;
    chk("r7_busy_before_wr", {31'd0, rs_busy_a}, 32'h1);
    tick;
    RFWr = 1'b0;
    #1;
    chk("r7_cleared_by_wr", {31'd0, rs_busy_a}, 32'h0);
    chk("r7_data", RD1_b, 32'h1);
    WD = 32'h55; RFWr = 1'b1;
    tick;
    // Reserve and write on the same register: reserve wins, data lands
    rsv_en = 1'b1; rsv_addr = 5'd7; WD = 32'h1; RFWr = 1'b1;
    tick;
    rsv_en = 1'b0; RFWr = 1'b0;
    #1;
    chk("r7_rsv_wins", {31'd0, rs_busy_a}, 32'h1);
    chk("r7_rsv_wr_data", RD1_b, 32'h1);

    // Fill r1..r31, then sweep-clear
    for (int i = 1; i < 32; i++) begin
      rd = 5'(i); WD = 32'h01010101 * i; RFWr = 1'b1;
      tick;
    end
    RFWr = 1'b0; clr_req = 1'b1;
    tick;
    rs = 5'd3; rd = 5'd3; WD = 32'hFFFFFFFF; RFWr = 1'b1;
    rsv_en = 1'b1; rsv_addr = 5'd4;
    #1;
    chk("sweep_no_bypass", RD1_a, 32'h03030303);
    cnt = 0;
    while (clr_busy_a && cnt < 100) begin
      clr_req = (cnt < 20);
      cnt++;
      tick;
    end
    clr_req = 1'b0; RFWr = 1'b0; rsv_en = 1'b0;
    chk("sweep_cycles", cnt, 32'd31);
    chk("sweep_done_nob", {31'd0, clr_busy_b}, 32'h0);
    rs = 5'd7;
    #1;
    chk("sweep_pend_clr", {31'd0, rs_busy_a}, 32'h0);
    rs = 5'd4;
    #1;
    chk("sweep_rsv_ignored", {31'd0, rs_busy_a}, 32'h0);
    for (int i = 1; i < 32; i++) begin
      rs = 5'(i); rt = 5'(i);
      #1;
      chk($sformatf("sweep_zero_r%0d", i), RD1_a | RD2_b, 32'h0);
    end
    tick;
    chk("idle_after_sweep", {31'd0, clr_busy_a}, 32'h0);

    // Reset in the middle of a sweep
    rd = 5'd10; WD = 32'hBB; RFWr = 1'b1; tick;
    rd = 5'd20; WD = 32'hCC; tick;
    RFWr = 1'b0; clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    repeat (9) tick;
    rs = 5'd10; rt = 5'd20;
    #1;
    chk("mid_sweep_busy", {31'd0, clr_busy_a}, 32'h1);
    chk("r10_before_swept", RD1_b, 32'hBB);
    rst = 1'b1;
    #1;
    chk("rst_drops_busy", {30'd0, clr_busy_a, clr_busy_b}, 32'h0);
    chk("rst_r10_zero", RD1_b, 32'h0);
    chk("rst_r20_zero", RD2_b, 32'h0);
    #1;
    rst = 1'b0;
    tick; tick;
    chk("idle_after_rst", {30'd0, clr_busy_a, clr_busy_b}, 32'h0);
    rd = 5'd20; WD = 32'h77; RFWr = 1'b1;
    tick;
    RFWr = 1'b0;
    #1;
    chk("write_after_rst", RD2_b, 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_param.md
RF_PARAM -- requirements
Module: rf_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth = 2^ADDR_W registers.
REQ-003 The block SHALL have parameter BYPASS, default 1, write-to-read forwarding enable (0/1).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, on these ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have these remaining ports:
- rs  in  ADDR_W  read port 1 address.
- rt  in  ADDR_W  read port 2 address.
- rd  in  ADDR_W  write address.
- WD  in  DATA_W  write data.
- RFWr  in  1  write enable.
- RD1  out  DATA_W  read data, port 1.
- RD2  out  DATA_W  read data, port 2.
- rsv_en  in  1  reserve (mark pending) register rsv_addr.
- rsv_addr  in  ADDR_W  register to reserve.
- rs_busy  out  1  pending bit of register rs.
- rt_busy  out  1  pending bit of register rt.
- clr_req  in  1  one-cycle request to start a register-file sweep-clear.
- clr_busy  out  1  sweep-clear in progress.

Function
REQ-006 Register 0 SHALL read as 0 on both ports at all times and SHALL ignore writes.
REQ-007 Reads SHALL be combinational: RD1 = reg[rs], RD2 = reg[rt], zero latency.
REQ-008 When RFWr=1, rd!=0 and clr_busy=0, reg[rd] SHALL take WD at the rising clk edge.
REQ-009 With BYPASS=1, clr_busy=0, RFWr=1 and rd==rs!=0, RD1 SHALL equal WD in the same cycle; RD2 likewise for rd==rt.
REQ-010 With BYPASS=0, reads SHALL return the stored value only; a write becomes visible the cycle after the edge.
REQ-011 The block SHALL keep one pending bit per register; pend[0] SHALL be constant 0.
REQ-012 When rsv_en=1, rsv_addr!=0 and clr_busy=0, pend[rsv_addr] SHALL be set at the edge.
REQ-013 A qualifying write (REQ-008) SHALL clear pend[rd] at the edge.
REQ-014 If a reserve and a write target the same register in one cycle, the reserve SHALL win (pend stays 1, data is written).
REQ-015 rs_busy = pend[rs] and rt_busy = pend[rt], combinational.
REQ-016 The block SHALL use a two-state FSM, IDLE and CLEAR; it SHALL leave reset in IDLE.
REQ-017 IDLE -> CLEAR SHALL occur on an edge with clr_req=1; at that edge all pend bits SHALL be cleared and the sweep index SHALL be loaded with 1.
REQ-018 In CLEAR, each cycle SHALL write 0 to reg[index] and increment the index.
REQ-019 The sweep SHALL end by writing index 2^ADDR_W-1 and returning to IDLE on that edge; CLEAR therefore lasts 2^ADDR_W-1 cycles.
REQ-020 clr_busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-021 In CLEAR, RFWr, rsv_en and clr_req SHALL be ignored and bypass SHALL be inactive; reads SHALL return the current array contents.
REQ-022 The sweep index SHALL be ADDR_W bits wide and SHALL NOT wrap past 2^ADDR_W-1.

Reset
REQ-023 On rst=1, the block SHALL immediately, independent of clk, clear all registers and pend bits to 0, set the FSM to IDLE and set the index to 0.
REQ-024 Under reset, RD1, RD2, rs_busy, rt_busy and clr_busy SHALL be 0.
REQ-025 Reset asserted during CLEAR SHALL abort the sweep, and no CLEAR state SHALL persist after release.

Configuration
REQ-026 With macro RF_TRACE_EN defined, each rising clk edge SHALL $display all registers, eight per line in %8X format, plus FSM state and pend vector.
REQ-027 Without RF_TRACE_EN, the block SHALL contain no display statements and its behaviour SHALL be otherwise identical.

Verification
REQ-028 The bench SHALL write 0xDEADBEEF to r5 with rs=5 in the same cycle -> RD1=0xDEADBEEF before the edge (BYPASS=1); with BYPASS=0, RD1 shows the old value, then 0xDEADBEEF the next cycle.
REQ-029 The bench SHALL write 0x12345678 to r0, then read rs=0 -> RD1=0, and rsv_addr=0 -> rs_busy stays 0.
REQ-030 The bench SHALL reserve r7, then write r7=0x1 -> rs_busy(rs=7) is 1 for one cycle, then 0; reserving and writing r7 together -> rs_busy stays 1 and RD1=0x1.
REQ-031 The bench SHALL fill r1..r31 with nonzero data and pulse clr_req -> clr_busy is high for exactly 31 cycles, RFWr during the sweep has no effect, and all registers read 0 afterwards.
REQ-032 The bench SHALL assert rst mid-sweep (index 10), asynchronously between edges -> clr_busy drops at once, all registers read 0, and the FSM is IDLE after release.
